// File: rtl/kmap_scan_pkg.sv
// ============================================================================
// kmap_scan_pkg : shared types, widths and helpers for the K-map scanner.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package kmap_scan_pkg;

  localparam int TT_W  = 16;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;
  localparam int POP_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } kmap_scan_state_t;

  // Truth-table bit position for mux select ab and sweep index cd.
  function automatic logic [SEL_W*2-1:0] tt_index(input logic [SEL_W-1:0] ab,
                                                  input logic [SEL_W-1:0] cd);
    return {ab, cd};
  endfunction

endpackage

`default_nettype wire

// File: rtl/kmap_mux_scanner_if.sv
// ============================================================================
// kmap_mux_scanner_if : sweep/sample and truth-table handshake signal bundle.
// Optional ones_count member under KMAP_SCAN_POPCOUNT_EN.
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface kmap_mux_scanner_if;
  import kmap_scan_pkg::*;

  logic                start;
  logic                c;
  logic                d;
  logic [3:0]          mux_in;
  logic                busy;
  logic                tt_valid;
  logic                tt_ready;
  logic [TT_W-1:0]     tt_data;
`ifdef KMAP_SCAN_POPCOUNT_EN
  logic [POP_W-1:0]    ones_count;
`endif

  // master: the scanner; slave: upstream stage plus downstream consumer.
  modport master (
    input  start, mux_in, tt_ready,
    output c, d, busy, tt_valid, tt_data
`ifdef KMAP_SCAN_POPCOUNT_EN
    , output ones_count
`endif
  );

  modport slave (
    output start, mux_in, tt_ready,
    input  c, d, busy, tt_valid, tt_data
`ifdef KMAP_SCAN_POPCOUNT_EN
    , input ones_count
`endif
  );

endinterface

`default_nettype wire

// File: rtl/kmap_popcount16.sv
// ============================================================================
// kmap_popcount16 : 16-bit population count, 5-bit result.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module kmap_popcount16 (
  input  wire logic [15:0] data_i,
  output logic      [4:0]  count_o
);

  always_comb begin
    count_o = 5'd0;
    for (int i = 0; i < 16; i++) begin
      count_o = count_o + 5'(data_i[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/kmap_mux_scanner.sv
// ============================================================================
// kmap_mux_scanner : sweeps {c,d} over the upstream K-map stage and assembles
// the 16-entry truth table of f(a,b,c,d). Optional KMAP_SCAN_POPCOUNT_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module kmap_mux_scanner
  import kmap_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 0
) (
  input  wire logic         clk,
  input  wire logic         reset,
  kmap_mux_scanner_if.master scan
);

  localparam bit               HAS_SETTLE  = (SETTLE_CYCLES > 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = HAS_SETTLE ? CNT_W'(SETTLE_CYCLES - 1)
                                                        : '0;

  kmap_scan_state_t   state_q, state_d;
  logic [SEL_W-1:0]   cd_q, cd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TT_W-1:0]    tt_q, tt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    case (state_q)
      ST_IDLE: begin
        cd_d  = '0;
        cnt_d = '0;
        if (scan.start) begin
          state_d = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        for (int ab = 0; ab < 4; ab++) begin
          tt_d[tt_index(SEL_W'(ab), cd_q)] = scan.mux_in[ab];
        end
        // Last index goes straight to DONE, so the 2-bit index never wraps.
        if (cd_q == SEL_W'(3)) begin
          state_d = ST_DONE;
        end else begin
          cd_d    = cd_q + SEL_W'(1);
          state_d = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
        end
      end
      ST_DONE: begin
        if (scan.tt_ready) begin
          state_d = ST_IDLE;
          cd_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign scan.c        = cd_q[1];
  assign scan.d        = cd_q[0];
  assign scan.busy     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign scan.tt_valid = (state_q == ST_DONE);
  assign scan.tt_data  = tt_q;

`ifdef KMAP_SCAN_POPCOUNT_EN
  logic [POP_W-1:0] ones_q;
  logic [POP_W-1:0] ones_d;

  kmap_popcount16 u_popcount (
    .data_i  (tt_d),
    .count_o (ones_d)
  );

  // Captured from the completed table on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_q <= '0;
    end else if ((state_q == ST_SAMPLE) && (state_d == ST_DONE)) begin
      ones_q <= ones_d;
    end
  end

  assign scan.ones_count = ones_q;
`endif

endmodule

`default_nettype wire
